// File: rtl/split_n_buf.sv
// N-way conditional split: joins one L token with one C select token and routes the data
// into a per-output FIFO, so one stalled consumer only blocks traffic aimed at itself.
module split_n_buf #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int DEPTH = 2,
    localparam int SELW = $clog2(N),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   L_data,
    input  logic               L_valid,
    output logic               L_ready,
    input  logic [SELW-1:0]    C_data,
    input  logic               C_valid,
    output logic               C_ready,
    output logic [N*WIDTH-1:0] O_data,
    output logic [N-1:0]       O_valid,
    input  logic [N-1:0]       O_ready,
    output logic               oob_err,
    output logic [N*CW-1:0]    occ
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic         fire;
    logic [N-1:0] pushEn;
    logic [N-1:0] popEn;
    logic         oob_q, oob_d;

    // A select with no matching output is still consumed; it just writes nothing.
    always_comb begin
        fire   = 1'b0;
        pushEn = '0;
        if (L_valid && C_valid && !reset) begin
            fire = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (C_data == SELW'(i)) begin
                    fire      = (occ[i*CW +: CW] != FULL);
                    pushEn[i] = fire;
                end
            end
        end
    end

    assign L_ready = fire;
    assign C_ready = fire;
    assign oob_d   = fire && (pushEn == '0);
    assign oob_err = oob_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            oob_q <= 1'b0;
        end else begin
            oob_q <= oob_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : gFifo
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wrPtr_q, wrPtr_d;
        logic [PW-1:0]    rdPtr_q, rdPtr_d;
        logic [CW-1:0]    occ_q, occ_d;

        assign popEn[g] = (occ_q != '0) && O_ready[g];

        always_comb begin
            wrPtr_d = wrPtr_q;
            rdPtr_d = rdPtr_q;
            occ_d   = occ_q;
            if (pushEn[g]) begin
                wrPtr_d = (wrPtr_q == PW'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
            end
            if (popEn[g]) begin
                rdPtr_d = (rdPtr_q == PW'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (pushEn[g] && !popEn[g]) begin
                occ_d = occ_q + 1'b1;
            end else if (!pushEn[g] && popEn[g]) begin
                occ_d = occ_q - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                occ_q   <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    mem_q[k] <= '0;
                end
            end else begin
                wrPtr_q <= wrPtr_d;
                rdPtr_q <= rdPtr_d;
                occ_q   <= occ_d;
                if (pushEn[g]) begin
                    mem_q[wrPtr_q] <= L_data;
                end
            end
        end

        assign O_data[g*WIDTH +: WIDTH] = mem_q[rdPtr_q];
        assign O_valid[g]               = (occ_q != '0);
        assign occ[g*CW +: CW]          = occ_q;
    end

endmodule
